// File: rtl/crc_stream_engine.sv
// crc_stream_engine
// Frame-aware, multi-lane CRC engine. Each accepted beat folds up to
// DATA_BYTES bytes into the running CRC in a single cycle. On the last beat
// of a frame the finished CRC, the byte count and the compare result are
// registered, and a one-cycle crc_valid pulse announces them. Protocol
// anomalies (a start while a frame is open, or data while idle) are flagged
// with one-cycle pulses.

module crc_stream_engine #(
  parameter int unsigned          CRC_WIDTH   = 8,
  parameter logic [CRC_WIDTH-1:0] POLY        = 8'h07,
  parameter logic [CRC_WIDTH-1:0] INIT        = 8'hff,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT     = 8'hff,
  parameter bit                   REFLECT_IN  = 1'b1,
  parameter bit                   REFLECT_OUT = 1'b1,
  parameter int                   DATA_BYTES  = 4,
  parameter bit                   LEFT_ALIGN  = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 din_valid,
  input  logic                                 din_start,
  input  logic                                 din_last,
  input  logic [$clog2(DATA_BYTES+1)-1:0]      din_len,
  input  logic [8*DATA_BYTES-1:0]              din,
  input  logic [CRC_WIDTH-1:0]                 crc_expected,
  output logic                                 crc_valid,
  output logic [CRC_WIDTH-1:0]                 crc_out,
  output logic                                 crc_ok,
  output logic [15:0]                          frame_len,
  output logic                                 frame_abort,
  output logic                                 orphan_beat
);

  localparam int                LEN_W   = $clog2(DATA_BYTES + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(DATA_BYTES);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Fold one byte into the CRC, bit-serially, in the configured bit order.
  function automatic logic [CRC_WIDTH-1:0] crc_byte(
    input logic [CRC_WIDTH-1:0] c_in,
    input logic [7:0]           b_in
  );
    logic [CRC_WIDTH-1:0] c;
    logic                 bit_v;
    logic                 fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (REFLECT_IN) begin
        bit_v = b_in[i];
      end else begin
        bit_v = b_in[7-i];
      end
      fb = bit_v ^ c[CRC_WIDTH-1];
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : {CRC_WIDTH{1'b0}});
    end
    return c;
  endfunction

  // Reverse the bit order of a CRC-width word.
  function automatic logic [CRC_WIDTH-1:0] bitrev(input logic [CRC_WIDTH-1:0] c_in);
    logic [CRC_WIDTH-1:0] r;
    r = {CRC_WIDTH{1'b0}};
    for (int i = 0; i < int'(CRC_WIDTH); i++) begin
      r[i] = c_in[int'(CRC_WIDTH)-1-i];
    end
    return r;
  endfunction

  // Pick the k-th byte in stream order; the first byte sits either at the
  // top of the beat or at the bottom depending on alignment.
  function automatic logic [7:0] lane_byte(
    input logic [8*DATA_BYTES-1:0] d,
    input int                      k
  );
    logic [7:0] b;
    if (LEFT_ALIGN) begin
      b = d[8*(DATA_BYTES-1-k) +: 8];
    end else begin
      b = d[8*k +: 8];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CRC_WIDTH-1:0] r_crc;
  logic [15:0]          r_cnt;

  logic                 r_crc_valid;
  logic [CRC_WIDTH-1:0] r_crc_out;
  logic                 r_crc_ok;
  logic [15:0]          r_frame_len;
  logic                 r_frame_abort;
  logic                 r_orphan_beat;

  // ---------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------
  logic                 w_take;
  logic                 w_finish;
  logic                 w_abort;
  logic                 w_orphan;
  logic [LEN_W-1:0]     w_len_sat;
  logic [CRC_WIDTH-1:0] w_crc_upd;
  logic [CRC_WIDTH-1:0] w_crc_final;
  logic [15:0]          w_cnt_base;
  logic [16:0]          w_cnt_sum;
  logic [15:0]          w_cnt_nxt;

  // Classify the incoming beat against the current frame state.
  always_comb begin
    w_take   = 1'b0;
    w_abort  = 1'b0;
    w_orphan = 1'b0;
    if (din_valid) begin
      if (din_start) begin
        w_take  = 1'b1;
        w_abort = (r_state == ST_ACTIVE);
      end else if (r_state == ST_ACTIVE) begin
        w_take = 1'b1;
      end else begin
        w_orphan = 1'b1;
      end
    end else begin
      w_take = 1'b0;
    end
    w_finish = w_take & din_last;
  end

  // Next-state logic: IDLE opens a frame on a start beat that is not also
  // the last one; ACTIVE closes on any accepted last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (din_valid && din_start && !din_last) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (din_valid && din_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Fold the valid lanes of this beat into the CRC; a start beat seeds from
  // INIT so a new frame never inherits state from an aborted one.
  always_comb begin
    w_len_sat = (din_len > MAX_LEN) ? MAX_LEN : din_len;
    if (din_start) begin
      w_crc_upd = INIT;
    end else begin
      w_crc_upd = r_crc;
    end
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (k < int'(w_len_sat)) begin
        w_crc_upd = crc_byte(w_crc_upd, lane_byte(din, k));
      end else begin
        w_crc_upd = w_crc_upd;
      end
    end
    if (REFLECT_OUT) begin
      w_crc_final = bitrev(w_crc_upd) ^ XOR_OUT;
    end else begin
      w_crc_final = w_crc_upd ^ XOR_OUT;
    end
  end

  // Running byte count with saturation at 16'hffff instead of wrapping.
  always_comb begin
    if (din_start) begin
      w_cnt_base = 16'h0000;
    end else begin
      w_cnt_base = r_cnt;
    end
    w_cnt_sum = {1'b0, w_cnt_base} + {{(17-LEN_W){1'b0}}, w_len_sat};
    if (w_cnt_sum[16]) begin
      w_cnt_nxt = 16'hffff;
    end else begin
      w_cnt_nxt = w_cnt_sum[15:0];
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Running CRC and byte count; both rearm on frame completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= INIT;
      r_cnt <= 16'h0000;
    end else if (w_finish) begin
      r_crc <= INIT;
      r_cnt <= 16'h0000;
    end else if (w_take) begin
      r_crc <= w_crc_upd;
      r_cnt <= w_cnt_nxt;
    end else begin
      r_crc <= r_crc;
      r_cnt <= r_cnt;
    end
  end

  // Result registers: captured on the last beat and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc_out   <= {CRC_WIDTH{1'b0}};
      r_crc_ok    <= 1'b0;
      r_frame_len <= 16'h0000;
    end else if (w_finish) begin
      r_crc_out   <= w_crc_final;
      r_crc_ok    <= (w_crc_final == crc_expected);
      r_frame_len <= w_cnt_nxt;
    end else begin
      r_crc_out   <= r_crc_out;
      r_crc_ok    <= r_crc_ok;
      r_frame_len <= r_frame_len;
    end
  end

  // One-cycle event pulses for completion and protocol anomalies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc_valid   <= 1'b0;
      r_frame_abort <= 1'b0;
      r_orphan_beat <= 1'b0;
    end else begin
      r_crc_valid   <= w_finish;
      r_frame_abort <= w_abort;
      r_orphan_beat <= w_orphan;
    end
  end

  assign crc_valid   = r_crc_valid;
  assign crc_out     = r_crc_out;
  assign crc_ok      = r_crc_ok;
  assign frame_len   = r_frame_len;
  assign frame_abort = r_frame_abort;
  assign orphan_beat = r_orphan_beat;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench for crc_stream_engine. Instance A uses the default
// (reflected, INIT/XOR_OUT = ff) configuration; instance B uses the plain
// MSB-first configuration with INIT = XOR_OUT = 0. Expected results are
// queued when the last beat is issued and checked by a separate monitor.

module tb_crc_stream_engine;

  typedef struct {
    logic [7:0]  crc;
    logic        chk_ok;
    logic        ok;
    logic [15:0] len;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        a_valid, a_start, a_last;
  logic [2:0]  a_len;
  logic [31:0] a_din;
  logic [7:0]  a_exp;
  logic        a_crc_valid, a_crc_ok, a_frame_abort, a_orphan;
  logic [7:0]  a_crc_out;
  logic [15:0] a_frame_len;

  logic        b_valid, b_start, b_last;
  logic [2:0]  b_len;
  logic [31:0] b_din;
  logic [7:0]  b_exp;
  logic        b_crc_valid, b_crc_ok, b_frame_abort, b_orphan;
  logic [7:0]  b_crc_out;
  logic [15:0] b_frame_len;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int a_abort_seen = 0, a_abort_exp = 0;
  int a_orphan_seen = 0, a_orphan_exp = 0;

  crc_stream_engine dut_a (
    .clk(clk), .rst_n(rst_n),
    .din_valid(a_valid), .din_start(a_start), .din_last(a_last),
    .din_len(a_len), .din(a_din), .crc_expected(a_exp),
    .crc_valid(a_crc_valid), .crc_out(a_crc_out), .crc_ok(a_crc_ok),
    .frame_len(a_frame_len), .frame_abort(a_frame_abort), .orphan_beat(a_orphan)
  );

  crc_stream_engine #(
    .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .INIT(8'h00), .XOR_OUT(8'h00)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .din_valid(b_valid), .din_start(b_start), .din_last(b_last),
    .din_len(b_len), .din(b_din), .crc_expected(b_exp),
    .crc_valid(b_crc_valid), .crc_out(b_crc_out), .crc_ok(b_crc_ok),
    .frame_len(b_frame_len), .frame_abort(b_frame_abort), .orphan_beat(b_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cmp_res(input string tag, input exp_t e, input logic [7:0] crc,
                         input logic ok, input logic [15:0] len);
    chk({tag, "_latency"}, cyc, e.due);
    chk({tag, "_crc_out"}, {24'h0, crc}, {24'h0, e.crc});
    chk({tag, "_frame_len"}, {16'h0, len}, {16'h0, e.len});
    if (e.chk_ok) chk({tag, "_crc_ok"}, {31'h0, ok}, {31'h0, e.ok});
  endtask

  // Monitor: pop and compare whenever a result or event pulse appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_crc_valid) begin
        if (qa.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL a_unexpected_crc_valid: got crc %0h, expected no result", a_crc_out);
        end else begin
          ea = qa.pop_front();
          cmp_res("a", ea, a_crc_out, a_crc_ok, a_frame_len);
        end
      end
      if (b_crc_valid) begin
        if (qb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_unexpected_crc_valid: got crc %0h, expected no result", b_crc_out);
        end else begin
          eb = qb.pop_front();
          cmp_res("b", eb, b_crc_out, b_crc_ok, b_frame_len);
        end
      end
      if (a_frame_abort) a_abort_seen++;
      if (a_orphan) a_orphan_seen++;
      if (b_frame_abort || b_orphan) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected_event: abort %0b orphan %0b, expected none", b_frame_abort, b_orphan);
      end
    end
  end

  // Queue an expected result for the last beat about to be issued.
  task automatic expect_res(input bit to_b, input logic [7:0] crc, input bit chk_ok,
                            input bit ok, input logic [15:0] len);
    exp_t e;
    e.crc = crc; e.chk_ok = chk_ok; e.ok = ok; e.len = len; e.due = cyc + 1;
    if (to_b) qb.push_back(e);
    else      qa.push_back(e);
  endtask

  // Present one beat for one clock edge, then drop valid.
  task automatic beat(input bit to_b, input bit st, input bit la, input logic [2:0] len,
                      input logic [31:0] d, input logic [7:0] ce);
    if (to_b) begin
      b_valid = 1'b1; b_start = st; b_last = la; b_len = len; b_din = d; b_exp = ce;
    end else begin
      a_valid = 1'b1; a_start = st; a_last = la; a_len = len; a_din = d; a_exp = ce;
    end
    @(posedge clk); #1;
    a_valid = 1'b0; a_start = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_start = 1'b0; b_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // "123456789" as three left-aligned beats; result queued on the last one.
  task automatic frame_9(input bit to_b, input logic [7:0] crc, input bit chk_ok,
                         input bit ok, input logic [7:0] ce);
    beat(to_b, 1'b1, 1'b0, 3'd4, 32'h31323334, 8'h00);
    beat(to_b, 1'b0, 1'b0, 3'd4, 32'h35363738, 8'h00);
    expect_res(to_b, crc, chk_ok, ok, 16'd9);
    beat(to_b, 1'b0, 1'b1, 3'd1, 32'h39000000, ce);
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_start = 1'b0; a_last = 1'b0; a_len = 3'd0; a_din = 32'h0; a_exp = 8'h0;
    b_valid = 1'b0; b_start = 1'b0; b_last = 1'b0; b_len = 3'd0; b_din = 32'h0; b_exp = 8'h0;
    #2;
    chk("rst_crc_valid", {31'h0, a_crc_valid}, 32'h0);
    chk("rst_crc_out", {24'h0, a_crc_out}, 32'h0);
    chk("rst_frame_len", {16'h0, a_frame_len}, 32'h0);
    chk("rst_flags", {29'h0, a_crc_ok, a_frame_abort, a_orphan}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Check string, default configuration.
    frame_9(1'b0, 8'h2F, 1'b0, 1'b0, 8'h00);
    idle(3);

    // Check string and single bytes, plain configuration.
    frame_9(1'b1, 8'hF4, 1'b0, 1'b0, 8'h00);
    idle(2);
    expect_res(1'b1, 8'h07, 1'b0, 1'b0, 16'd1);
    beat(1'b1, 1'b1, 1'b1, 3'd1, 32'h01FFFFFF, 8'h00);
    expect_res(1'b1, 8'h00, 1'b0, 1'b0, 16'd1);
    beat(1'b1, 1'b1, 1'b1, 3'd1, 32'h00FFFFFF, 8'h00);
    idle(3);

    // Back-to-back frames with a passing then failing compare value.
    frame_9(1'b0, 8'h2F, 1'b1, 1'b1, 8'h2F);
    frame_9(1'b0, 8'h2F, 1'b1, 1'b0, 8'h2E);
    idle(3);

    // Restart mid-frame: first frame dropped, second completes.
    beat(1'b0, 1'b1, 1'b0, 3'd4, 32'hAABBCCDD, 8'h00);
    beat(1'b0, 1'b0, 1'b0, 3'd4, 32'h11223344, 8'h00);
    a_abort_exp++;
    frame_9(1'b0, 8'h2F, 1'b0, 1'b0, 8'h00);
    idle(3);

    // Orphan beats while idle, then a clean frame.
    a_orphan_exp++;
    beat(1'b0, 1'b0, 1'b0, 3'd4, 32'hDEADBEEF, 8'h00);
    idle(1);
    a_orphan_exp++;
    beat(1'b0, 1'b0, 1'b1, 3'd4, 32'hDEADBEEF, 8'h00);
    idle(2);
    frame_9(1'b0, 8'h2F, 1'b0, 1'b0, 8'h00);
    idle(3);

    // Empty frame: transformed INIT, zero length.
    expect_res(1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
    beat(1'b0, 1'b1, 1'b1, 3'd0, 32'hFFFFFFFF, 8'h00);
    idle(3);

    // Length above the lane count saturates to four bytes.
    expect_res(1'b1, 8'h07, 1'b0, 1'b0, 16'd4);
    beat(1'b1, 1'b1, 1'b1, 3'd7, 32'h00000001, 8'h00);
    idle(3);

    // Build up a held result, open a frame, then reset asynchronously.
    frame_9(1'b0, 8'h2F, 1'b1, 1'b1, 8'h2F);
    idle(2);
    beat(1'b0, 1'b1, 1'b0, 3'd4, 32'h31323334, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_crc_out", {24'h0, a_crc_out}, 32'h0);
    chk("async_rst_frame_len", {16'h0, a_frame_len}, 32'h0);
    chk("async_rst_flags", {28'h0, a_crc_valid, a_crc_ok, a_frame_abort, a_orphan}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(3);
    a_orphan_exp++;
    beat(1'b0, 1'b0, 1'b1, 3'd1, 32'h39000000, 8'h00);
    idle(4);

    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);
    chk("a_abort_count", a_abort_seen, a_abort_exp);
    chk("a_orphan_count", a_orphan_seen, a_orphan_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
